color_scan_sequencer: RTL

Controller that sequences the TCS3200-style colour sensor front end through its four photodiode filters (red, blue, green, clear). For each filter it waits a settle interval, counts rising edges of the sensor's frequency output over a fixed gate window, then stores the count. All four counts are published together with a one-cycle `done` pulse. It sits between the sensor pins and the colour classifier, which consumes the four counts instead of sampling a single free-running frequency.

---
 rtl/color_scan_sequencer_if.sv | 32 +++
 rtl/color_scan_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/color_scan_sequencer_if.sv
// Pin and result bundle between a colour-scan controller (slave) and its host/sensor side (master).
// The four channel counts and sat flags are valid whenever done pulses and stay stable until the next pulse.
interface color_scan_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             continuous;
  logic             abort;
  logic             sensor_freq;
  logic [1:0]       scale;
  logic [1:0]       filter;
  logic             enf;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] red_cnt;
  logic [CNT_W-1:0] blue_cnt;
  logic [CNT_W-1:0] green_cnt;
  logic [CNT_W-1:0] clear_cnt;
  logic [3:0]       sat;

  modport master (
    output start, continuous, abort, sensor_freq,
    input  scale, filter, enf, busy, done,
    input  red_cnt, blue_cnt, green_cnt, clear_cnt, sat
  );

  modport slave (
    input  start, continuous, abort, sensor_freq,
    output scale, filter, enf, busy, done,
    output red_cnt, blue_cnt, green_cnt, clear_cnt, sat
  );
endinterface

// File: rtl/color_scan_sequencer.sv
// Steps a TCS3200-style sensor through red/blue/green/clear, gating edge counts per filter.
// Counts publish with a done pulse 4*(S+G+1)+1 cycles after start; no backpressure, abort discards a scan.
module color_scan_sequencer #(
  parameter int         GATE_CYCLES   = 1000000,
  parameter int         SETTLE_CYCLES = 1000,
  parameter int         CNT_W         = 16,
  parameter logic [1:0] SCALE         = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  color_scan_sequencer_if.slave bus
);

  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE,
    S_STORE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [TW-1:0]    tmr_q, tmr_d;

  logic             sync1_q, sync2_q, sync3_q;
  logic             edge_det;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] red_sh_q, blue_sh_q, green_sh_q;
  logic [3:0]       sat_sh_q;
  logic [CNT_W-1:0] red_q, blue_q, green_q, clear_q;
  logic [3:0]       sat_q;

  logic             busy;
  logic             gate_open;
  logic             publish;

  assign edge_det = sync2_q & ~sync3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = S_SETTLE;
          idx_d   = 2'd0;
          tmr_d   = '0;
        end
      end
      S_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d = S_GATE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_GATE: begin
        if (tmr_q == GATE_LAST) begin
          state_d = S_STORE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_STORE: begin
        if (idx_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETTLE;
          idx_d   = idx_q + 2'd1;
        end
      end
      S_DONE: begin
        idx_d = 2'd0;
        if (bus.continuous) begin
          state_d = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
        tmr_d   = '0;
      end
    endcase
    // abort overrides every transition, including a pending publish
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = 2'd0;
      tmr_d   = '0;
    end
  end

  assign gate_open = (state_q == S_SETTLE) && (state_d == S_GATE);
  assign publish   = (state_q == S_STORE) && (state_d == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      cnt_q      <= '0;
      sat_sh_q   <= 4'b0000;
      red_sh_q   <= '0;
      blue_sh_q  <= '0;
      green_sh_q <= '0;
      red_q      <= '0;
      blue_q     <= '0;
      green_q    <= '0;
      clear_q    <= '0;
      sat_q      <= 4'b0000;
    end else begin
      sync1_q <= bus.sensor_freq;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;

      if (gate_open) begin
        cnt_q           <= '0;
        sat_sh_q[idx_q] <= 1'b0;
      end else if ((state_q == S_GATE) && edge_det) begin
        if (cnt_q == CNT_MAX) begin
          sat_sh_q[idx_q] <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      if (state_q == S_STORE) begin
        case (idx_q)
          2'd0:    red_sh_q   <= cnt_q;
          2'd1:    blue_sh_q  <= cnt_q;
          2'd2:    green_sh_q <= cnt_q;
          default: ;
        endcase
      end

      // clear channel goes straight from the counter so counts appear in the DONE cycle
      if (publish) begin
        red_q   <= red_sh_q;
        blue_q  <= blue_sh_q;
        green_q <= green_sh_q;
        clear_q <= cnt_q;
        sat_q   <= sat_sh_q;
      end
    end
  end

  assign busy = (state_q != S_IDLE);

  always_comb begin
    bus.filter = 2'b00;
    if (busy) begin
      case (idx_q)
        2'd0:    bus.filter = 2'b00;
        2'd1:    bus.filter = 2'b01;
        2'd2:    bus.filter = 2'b11;
        default: bus.filter = 2'b10;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.enf       = busy;
  assign bus.scale     = busy ? SCALE : 2'b00;
  assign bus.done      = (state_q == S_DONE);
  assign bus.red_cnt   = red_q;
  assign bus.blue_cnt  = blue_q;
  assign bus.green_cnt = green_q;
  assign bus.clear_cnt = clear_q;
  assign bus.sat       = sat_q;

endmodule
